aes_xfer_controller: RTL

AES_XFER_CONTROLLER -- requirements
Module: aes_xfer_controller

---
 rtl/aes_xfer_controller.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_xfer_controller.sv
// aes_xfer_controller: moves a job of 128-bit blocks from memory through an
// AES core and back. Each block is read as four 32-bit words, ciphered, and
// written back as four 32-bit words.
// Ports:
//   hclk, hrst          clock and asynchronous active-low reset
//   start, abort        job launch pulse and level cancel request
//   src_addr, dst_addr  byte addresses of the first source/destination word
//   num_blocks          block count of the job
//   bus_*               word-transfer handshake toward the AHB master
//   aes_*               cipher launch/result handshake
//   busy, done, error   job status (done is a pulse, error is sticky)
//   blocks_done         blocks fully stored in the current/last job
module aes_xfer_controller #(
  parameter int unsigned CNT_W = 16
) (
  input  logic              hclk,
  input  logic              hrst,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       src_addr,
  input  logic [31:0]       dst_addr,
  input  logic [CNT_W-1:0]  num_blocks,
  output logic              bus_req,
  output logic              bus_write,
  output logic [31:0]       bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_err,
  output logic              aes_start,
  output logic [127:0]      aes_din,
  input  logic              aes_done,
  input  logic [127:0]      aes_dout,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  blocks_done
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned IDX_W  = 2;
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(3);

  typedef enum logic [2:0] {IDLE, FETCH, CIPHER, WAIT_AES, STORE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0]  dst_ptr_q, dst_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLK_W-1:0]   result_q, result_d;

  logic               bus_req_d, bus_write_d, aes_start_d;
  logic               busy_d, done_d, error_d;
  logic [ADDR_W-1:0]  bus_addr_d;
  logic [WORD_W-1:0]  bus_wdata_d;
  logic [BLK_W-1:0]   aes_din_d;
  logic [CNT_W-1:0]   blocks_done_d;

  logic               ack_c;
  logic               stop_c;
  logic [CNT_W-1:0]   bd_inc_c;

  // Word 0 is the most significant 32 bits of a block.
  function automatic logic [WORD_W-1:0] blk_word(input logic [BLK_W-1:0] blk,
                                                 input logic [IDX_W-1:0] idx);
    logic [WORD_W-1:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

  function automatic logic [BLK_W-1:0] blk_put(input logic [BLK_W-1:0]  blk,
                                               input logic [IDX_W-1:0]  idx,
                                               input logic [WORD_W-1:0] w);
    logic [BLK_W-1:0] r;
    r = blk;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

  // An ack only counts while a request is outstanding.
  assign ack_c    = bus_req & bus_ack;
  // Error and abort share the same exit; error wins trivially since both set error.
  assign stop_c   = bus_err | abort;
  assign bd_inc_c = blocks_done + CNT_W'(1);

  // State register.
  always_ff @(posedge hclk or negedge hrst) begin
    if (!hrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and next values of all registered outputs and datapath.
  always_comb begin
    state_d       = state_q;
    src_ptr_d     = src_ptr_q;
    dst_ptr_d     = dst_ptr_q;
    count_d       = count_q;
    idx_d         = idx_q;
    result_d      = result_q;
    bus_req_d     = bus_req;
    bus_write_d   = bus_write;
    bus_addr_d    = bus_addr;
    bus_wdata_d   = bus_wdata;
    aes_din_d     = aes_din;
    blocks_done_d = blocks_done;
    error_d       = error;
    aes_start_d   = 1'b0;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (num_blocks == '0) begin
            done_d = 1'b1;
          end else begin
            src_ptr_d     = src_addr;
            dst_ptr_d     = dst_addr;
            count_d       = num_blocks;
            blocks_done_d = '0;
            idx_d         = '0;
            bus_req_d     = 1'b1;
            bus_write_d   = 1'b0;
            bus_addr_d    = src_addr;
            state_d       = FETCH;
          end
        end
      end

      FETCH: begin
        if (ack_c) begin
          bus_req_d = 1'b0;
          if (stop_c) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else begin
            aes_din_d = blk_put(aes_din, idx_q, bus_rdata);
            src_ptr_d = src_ptr_q + WORD_BYTES;
            idx_d     = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
              aes_start_d = 1'b1;
              state_d     = CIPHER;
            end
          end
        end else if (!bus_req) begin
          // Re-request after the mandatory idle cycle following an ack.
          bus_req_d   = 1'b1;
          bus_write_d = 1'b0;
          bus_addr_d  = src_ptr_q;
        end
      end

      CIPHER: begin
        state_d = WAIT_AES;
      end

      WAIT_AES: begin
        if (aes_done) begin
          if (abort) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else begin
            result_d    = aes_dout;
            idx_d       = '0;
            bus_req_d   = 1'b1;
            bus_write_d = 1'b1;
            bus_addr_d  = dst_ptr_q;
            bus_wdata_d = aes_dout[127:96];
            state_d     = STORE;
          end
        end
      end

      STORE: begin
        if (ack_c) begin
          bus_req_d = 1'b0;
          if (stop_c) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else begin
            dst_ptr_d = dst_ptr_q + WORD_BYTES;
            idx_d     = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
              blocks_done_d = bd_inc_c;
              if (bd_inc_c == count_q) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end else begin
                state_d = FETCH;
              end
            end
          end
        end else if (!bus_req) begin
          bus_req_d   = 1'b1;
          bus_write_d = 1'b1;
          bus_addr_d  = dst_ptr_q;
          bus_wdata_d = blk_word(result_q, idx_q);
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge hclk or negedge hrst) begin
    if (!hrst) begin
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      result_q    <= '0;
      bus_req     <= 1'b0;
      bus_write   <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      aes_start   <= 1'b0;
      aes_din     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      blocks_done <= '0;
    end else begin
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      bus_req     <= bus_req_d;
      bus_write   <= bus_write_d;
      bus_addr    <= bus_addr_d;
      bus_wdata   <= bus_wdata_d;
      aes_start   <= aes_start_d;
      aes_din     <= aes_din_d;
      busy        <= busy_d;
      done        <= done_d;
      error       <= error_d;
      blocks_done <= blocks_done_d;
    end
  end

endmodule
